// File: rtl/class_pop_arbiter.sv
// ============================================================================
// class_pop_arbiter
//   Weighted round-robin pop scheduler draining two class FIFOs into one
//   registered downstream port, with per-class forwarded-word counters.
//   Rev 1.0
// ============================================================================
`default_nettype none

module class_pop_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 3,
  parameter int WEIGHT1   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic [DATA_SIZE-1:0] data0,
  input  logic [DATA_SIZE-1:0] data1,
  input  logic                 down_afull,
  output logic                 pop_0,
  output logic                 pop_1,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_class,
  output logic [7:0]           cnt0,
  output logic [7:0]           cnt1
);

  typedef enum logic [0:0] {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  localparam logic [3:0] C_W0 = 4'(WEIGHT0);
  localparam logic [3:0] C_W1 = 4'(WEIGHT1);

  owner_e               owner_q, owner_d;
  logic [3:0]           credit_q, credit_d;
  logic                 vld_q, sel_q;
  logic [DATA_SIZE-1:0] out_data_q;
  logic                 out_valid_q, out_class_q;
  logic [7:0]           cnt0_q, cnt1_q;

  logic       w_elig0, w_elig1, w_elig_own, w_elig_oth;
  logic [3:0] w_wgt_own, w_wgt_oth;
  logic       w_grant_own, w_grant_oth;
  logic       w_grant0, w_grant1;

  always_comb begin
    owner_d     = owner_q;
    credit_d    = credit_q;
    w_grant_own = 1'b0;
    w_grant_oth = 1'b0;

    w_elig0    = !fifo_empty0 && !down_afull;
    w_elig1    = !fifo_empty1 && !down_afull;
    w_elig_own = (owner_q == OWN0) ? w_elig0 : w_elig1;
    w_elig_oth = (owner_q == OWN0) ? w_elig1 : w_elig0;
    w_wgt_own  = (owner_q == OWN0) ? C_W0 : C_W1;
    w_wgt_oth  = (owner_q == OWN0) ? C_W1 : C_W0;

    // Owner keeps the turn while it has credit; otherwise the other class
    // takes over, and an idle other class lets the owner reload (work-conserving).
    if (w_elig_own && (credit_q != 4'd0)) begin
      w_grant_own = 1'b1;
      credit_d    = credit_q - 4'd1;
    end else if (w_elig_oth) begin
      w_grant_oth = 1'b1;
      owner_d     = (owner_q == OWN0) ? OWN1 : OWN0;
      credit_d    = w_wgt_oth - 4'd1;
    end else if (w_elig_own) begin
      w_grant_own = 1'b1;
      credit_d    = w_wgt_own - 4'd1;
    end

    w_grant0 = (owner_q == OWN0) ? w_grant_own : w_grant_oth;
    w_grant1 = (owner_q == OWN0) ? w_grant_oth : w_grant_own;
  end

  // Pops are gated by reset so the FIFOs are never drained while held in reset.
  assign pop_0 = w_grant0 && reset;
  assign pop_1 = w_grant1 && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN0;
      credit_q    <= C_W0;
      vld_q       <= 1'b0;
      sel_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= 1'b0;
      cnt0_q      <= 8'd0;
      cnt1_q      <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      vld_q       <= pop_0 || pop_1;
      sel_q       <= pop_1;
      out_valid_q <= vld_q;
      out_class_q <= sel_q;
      if (vld_q) begin
        out_data_q <= sel_q ? data1 : data0;
      end
      if (pop_0) begin
        cnt0_q <= cnt0_q + 8'd1;
      end
      if (pop_1) begin
        cnt1_q <= cnt1_q + 8'd1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_class_pop_arbiter.sv
// ============================================================================
// tb_class_pop_arbiter
//   Scoreboard bench: FIFO models feed the arbiter, expected words are queued
//   at pop time and matched against the registered output two cycles later.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_class_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty0 = 1'b1;
  logic       fifo_empty1 = 1'b1;
  logic [9:0] data0 = '0;
  logic [9:0] data1 = '0;
  logic       down_afull = 1'b0;
  logic       pop_0, pop_1;
  logic [9:0] out_data;
  logic       out_valid, out_class;
  logic [7:0] cnt0, cnt1;

  class_pop_arbiter #(
    .DATA_SIZE(10),
    .WEIGHT0  (3),
    .WEIGHT1  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty0(fifo_empty0),
    .fifo_empty1(fifo_empty1),
    .data0      (data0),
    .data1      (data1),
    .down_afull (down_afull),
    .pop_0      (pop_0),
    .pop_1      (pop_1),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_class  (out_class),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cls;
    logic [9:0]  word;
    logic [31:0] at;
  } sb_t;

  sb_t        sb[$];
  logic [9:0] f0[$];
  logic [9:0] f1[$];
  logic       pend0 = 1'b0;
  logic       pend1 = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  logic [9:0] fair0 [4] = '{10'h0FF, 10'h0EE, 10'h0AA, 10'h0A7};
  logic [9:0] fair1 [4] = '{10'h2DD, 10'h2CC, 10'h299, 10'h288};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: read data appears the cycle after the pop; empty updates on the same edge
  always @(posedge clk) begin
    if (pend0 && f0.size() > 0) data0 <= f0.pop_front();
    if (pend1 && f1.size() > 0) data1 <= f1.pop_front();
    fifo_empty0 <= (f0.size() == 0);
    fifo_empty1 <= (f1.size() == 0);
  end

  always @(negedge clk) begin
    #1;
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check_eq("out_data", 32'(out_data), 32'(e.word));
        check_eq("out_class", 32'(out_class), 32'(e.cls));
        check_eq("latency_cycle", 32'(cyc), e.at);
      end
    end
  end

  // Called right after a negedge; returns right after the next negedge.
  // exp: 0 = no pop, 1 = pop_0, 2 = pop_1.
  task automatic tick(input bit af, input int exp);
    logic [1:0] want;
    sb_t        e;
    down_afull = af;
    #1;
    want = (exp == 1) ? 2'b01 : (exp == 2) ? 2'b10 : 2'b00;
    check_eq("pop", {30'd0, pop_1, pop_0}, {30'd0, want});
    pend0 = pop_0;
    pend1 = pop_1;
    if (pop_0 && f0.size() > 0) begin
      e.cls = 1'b0; e.word = f0[0]; e.at = 32'(cyc + 2);
      sb.push_back(e);
    end
    if (pop_1 && f1.size() > 0) begin
      e.cls = 1'b1; e.word = f1[0]; e.at = 32'(cyc + 2);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    down_afull = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    sb.delete();
    f0.delete();
    f1.delete();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic load_fair();
    for (int i = 0; i < 4; i++) begin
      f0.push_back(fair0[i]);
      f1.push_back(fair1[i]);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (3) tick(1'b0, 0);
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fair_seq [8] = '{1, 1, 1, 2, 1, 2, 2, 2};
    int bp_seq   [11] = '{1, 1, 0, 0, 0, 1, 2, 1, 2, 2, 2};
    bit bp_af    [11] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int mid_seq  [7] = '{1, 1, 1, 2, 2, 2, 2};

    @(negedge clk);

    // Reset held with both FIFOs non-empty, then fair share
    do_reset();
    load_fair();
    #1;
    check_eq("rst_pop", {30'd0, pop_1, pop_0}, 32'd0);
    check_eq("rst_out_valid_held", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'h000);
    check_eq("rst_cnt0", 32'(cnt0), 32'd0);
    check_eq("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, fair_seq[i]);
    drain("fair_drain");
    check_eq("fair_cnt0", 32'(cnt0), 32'd4);
    check_eq("fair_cnt1", 32'(cnt1), 32'd4);

    // Single class: only FIFO #1 holds words
    do_reset();
    for (int i = 0; i < 4; i++) f1.push_back(10'(10'h311 + i));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 2);
    tick(1'b0, 0);
    check_eq("single_cnt1", 32'(cnt1), 32'd4);
    check_eq("single_cnt0", 32'(cnt0), 32'd0);
    drain("single_drain");

    // Backpressure after the 2nd pop; credit must survive the stall
    do_reset();
    load_fair();
    reset = 1'b1;
    for (int i = 0; i < 11; i++) tick(bp_af[i], bp_seq[i]);
    drain("bp_drain");

    // Reset one cycle after a pop: that word must never emerge
    do_reset();
    load_fair();
    reset = 1'b1;
    tick(1'b0, 1);
    reset = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    sb.delete();
    #1;
    check_eq("mid_rst_valid0", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("mid_rst_valid1", 32'(out_valid), 32'd0);
    check_eq("mid_rst_cnt0", 32'(cnt0), 32'd0);
    check_eq("mid_rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick(1'b0, mid_seq[i]);
    drain("mid_drain");

    // Counter wrap on FIFO #0
    do_reset();
    for (int i = 0; i < 257; i++) f0.push_back(10'(i));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 257; i++) begin
      if (i == 255) check_eq("cnt0_255", 32'(cnt0), 32'd255);
      if (i == 256) check_eq("cnt0_wrap0", 32'(cnt0), 32'd0);
      tick(1'b0, 1);
    end
    check_eq("cnt0_wrap1", 32'(cnt0), 32'd1);
    drain("wrap_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
